// File: rtl/mux_pipe_arb_pkg.sv
// Shared arbitration mode encoding and parameter defaults for the two-source merge.
package mux_pipe_arb_pkg;

    typedef enum logic [1:0] {
        MODE_RR    = 2'd0,
        MODE_F_PRI = 2'd1,
        MODE_A_PRI = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int DEF_WIDTH        = 128;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mux_pipe_arb_slot.sv
// One-entry holding buffer; write lands next cycle, a same-cycle deq+enq keeps it full.
// Backpressure is decided by the owner, which only dequeues when granted.
module mux_pipe_arb_slot
    import mux_pipe_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enq_i,
    input  logic [WIDTH-1:0] enq_dat_i,
    input  logic             deq_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // Enqueue wins over dequeue so a refill in the draining cycle is not lost.
    always_comb begin
        valid_d = valid_q;
        dat_d   = dat_q;
        if (deq_i) begin
            valid_d = 1'b0;
        end
        if (enq_i) begin
            valid_d = 1'b1;
            dat_d   = enq_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            dat_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dat_q   <= dat_d;
        end
    end

    assign valid_o = valid_q;
    assign dat_o   = dat_q;

endmodule

// File: rtl/mux_pipe_arb.sv
// Merges sources A and F into one output via per-source slots; one cycle enq-to-out.
// Round-robin or fixed priority with starvation cap; nothing moves while out_enq__RDY is low.
module mux_pipe_arb
    import mux_pipe_arb_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_enq__ENA,
    input  logic [WIDTH-1:0] in_enq_v,
    output logic             in_enq__RDY,
    input  logic             forward_enq__ENA,
    input  logic [WIDTH-1:0] forward_enq_v,
    output logic             forward_enq__RDY,
    output logic             out_enq__ENA,
    output logic [WIDTH-1:0] out_enq_v,
    input  logic             out_enq__RDY,
    input  logic             cfg_setMode__ENA,
    input  logic [1:0]       cfg_setMode_v,
    output logic             cfg_setMode__RDY
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic             vld_a, vld_f;
    logic [WIDTH-1:0] dat_a, dat_f;
    logic             gnt_a, gnt_f;
    logic             np_vld, np_gnt;
    logic             lim_hit;
    mode_e            eff_mode;

    mode_e            mode_q, mode_d;
    logic             last_f_q, last_f_d;
    logic [3:0]       starve_q, starve_d;

    mux_pipe_arb_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk_i     (CLK),
        .rst_i     (RST),
        .enq_i     (in_enq__ENA),
        .enq_dat_i (in_enq_v),
        .deq_i     (gnt_a),
        .valid_o   (vld_a),
        .dat_o     (dat_a)
    );

    mux_pipe_arb_slot #(.WIDTH(WIDTH)) u_slot_f (
        .clk_i     (CLK),
        .rst_i     (RST),
        .enq_i     (forward_enq__ENA),
        .enq_dat_i (forward_enq_v),
        .deq_i     (gnt_f),
        .valid_o   (vld_f),
        .dat_o     (dat_f)
    );

    always_comb begin
        eff_mode = (mode_q == MODE_RSVD) ? MODE_RR : mode_q;
        lim_hit  = (starve_q == LIMIT);
        gnt_a    = 1'b0;
        gnt_f    = 1'b0;
        if (out_enq__RDY) begin
            if (vld_a && !vld_f) begin
                gnt_a = 1'b1;
            end else if (vld_f && !vld_a) begin
                gnt_f = 1'b1;
            end else if (vld_a && vld_f) begin
                case (eff_mode)
                    MODE_F_PRI: begin
                        gnt_a = lim_hit;
                        gnt_f = !lim_hit;
                    end
                    MODE_A_PRI: begin
                        gnt_f = lim_hit;
                        gnt_a = !lim_hit;
                    end
                    default: begin
                        gnt_a = last_f_q;
                        gnt_f = !last_f_q;
                    end
                endcase
            end
        end
    end

    // The starvation counter tracks whichever source is not favoured by the current mode.
    always_comb begin
        np_vld = 1'b0;
        np_gnt = 1'b0;
        case (eff_mode)
            MODE_F_PRI: begin
                np_vld = vld_a;
                np_gnt = gnt_a;
            end
            MODE_A_PRI: begin
                np_vld = vld_f;
                np_gnt = gnt_f;
            end
            default: begin
                np_vld = 1'b0;
                np_gnt = 1'b0;
            end
        endcase

        starve_d = starve_q;
        if (cfg_setMode__ENA) begin
            starve_d = '0;
        end else if (out_enq__RDY) begin
            if (np_gnt || !np_vld) begin
                starve_d = '0;
            end else if (starve_q < LIMIT) begin
                starve_d = starve_q + 4'd1;
            end
        end

        mode_d   = cfg_setMode__ENA ? mode_e'(cfg_setMode_v) : mode_q;
        last_f_d = gnt_f ? 1'b1 : (gnt_a ? 1'b0 : last_f_q);
    end

    // Last-grant resets to F so the first round-robin tie goes to A.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q   <= MODE_RR;
            last_f_q <= 1'b1;
            starve_q <= '0;
        end else begin
            mode_q   <= mode_d;
            last_f_q <= last_f_d;
            starve_q <= starve_d;
        end
    end

    assign out_enq__ENA     = gnt_a | gnt_f;
    assign out_enq_v        = gnt_a ? dat_a : (gnt_f ? dat_f : '0);
    assign in_enq__RDY      = !RST && (!vld_a || gnt_a);
    assign forward_enq__RDY = !RST && (!vld_f || gnt_f);
    assign cfg_setMode__RDY = !RST;

endmodule

// File: tb/tb_mux_pipe_arb.sv
// Directed and random stimulus for mux_pipe_arb against a cycle-level reference model.
module tb_mux_pipe_arb;
    import mux_pipe_arb_pkg::*;

    localparam int W   = 128;
    localparam int LIM = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         a_ena = 1'b0, f_ena = 1'b0, o_rdy = 1'b0, m_ena = 1'b0;
    logic [W-1:0] a_v = '0, f_v = '0;
    logic [1:0]   m_v = 2'd0;
    logic         a_rdy, f_rdy, o_ena, m_rdy;
    logic [W-1:0] o_v;

    always #5 CLK = ~CLK;

    mux_pipe_arb #(.WIDTH(W), .STARVE_LIMIT(LIM)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .in_enq__ENA      (a_ena),
        .in_enq_v         (a_v),
        .in_enq__RDY      (a_rdy),
        .forward_enq__ENA (f_ena),
        .forward_enq_v    (f_v),
        .forward_enq__RDY (f_rdy),
        .out_enq__ENA     (o_ena),
        .out_enq_v        (o_v),
        .out_enq__RDY     (o_rdy),
        .cfg_setMode__ENA (m_ena),
        .cfg_setMode_v    (m_v),
        .cfg_setMode__RDY (m_rdy)
    );

    // Reference state: slot contents, last winner (0=A,1=F), mode, starvation count.
    bit           mva, mvf;
    logic [W-1:0] mda, mdf;
    int           mlast, mmode, mcnt;
    int           checks = 0, errors = 0;
    int           seq_a = 0, seq_f = 0;
    bit           rnd_hi = 0;
    bit           force_a_en = 0;
    logic [W-1:0] force_a = '0;
    logic [W-1:0] obs_q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mva = 0; mvf = 0; mda = '0; mdf = '0;
        mlast = 1; mmode = 0; mcnt = 0;
    endtask

    function automatic logic [W-1:0] payload(input logic [3:0] tag, input int seq);
        logic [95:0] hi;
        hi = rnd_hi ? {$urandom(), $urandom(), $urandom()} : 96'h0;
        return {hi, 24'h0, tag, 4'(seq)};
    endfunction

    // One clock: entered and left at posedge+1.
    task automatic cyc(input bit wa, input bit wf, input bit ordy, input bit men, input logic [1:0] mv);
        int m;
        bit ga, gf, ra, rf, np_v, np_g;
        logic [W-1:0] pa, pf;
        m  = (mmode == 3) ? 0 : mmode;
        ga = 0; gf = 0;
        if (ordy) begin
            if (mva && !mvf) ga = 1;
            else if (mvf && !mva) gf = 1;
            else if (mva && mvf) begin
                if (m == 1)      begin if (mcnt == LIM) ga = 1; else gf = 1; end
                else if (m == 2) begin if (mcnt == LIM) gf = 1; else ga = 1; end
                else             begin if (mlast == 1) ga = 1; else gf = 1; end
            end
        end
        ra = !mva || ga;
        rf = !mvf || gf;
        pa = force_a_en ? force_a : payload(4'hA, seq_a);
        pf = payload(4'hF, seq_f);
        o_rdy = ordy;
        a_ena = wa && ra; a_v = pa;
        f_ena = wf && rf; f_v = pf;
        m_ena = men; m_v = mv;

        @(negedge CLK);
        chk("out_ena", o_ena, ga | gf);
        chk("out_v", o_v, ga ? mda : (gf ? mdf : '0));
        chk("a_rdy", a_rdy, ra);
        chk("f_rdy", f_rdy, rf);
        chk("cfg_rdy", m_rdy, 1);
        if (o_ena === 1'b1) obs_q.push_back(o_v);

        @(posedge CLK); #1;
        np_v = (m == 1) ? mva : mvf;
        np_g = (m == 1) ? ga : gf;
        if (men) mcnt = 0;
        else if (ordy) begin
            if (m == 0 || np_g || !np_v) mcnt = 0;
            else if (mcnt < LIM) mcnt++;
        end
        if (ga) begin mlast = 0; mva = 0; end
        if (gf) begin mlast = 1; mvf = 0; end
        if (men) mmode = int'(mv);
        if (a_ena) begin mva = 1; mda = pa; seq_a++; end
        if (f_ena) begin mvf = 1; mdf = pf; seq_f++; end
        a_ena = 0; f_ena = 0; m_ena = 0;
    endtask

    initial begin
        logic [W-1:0] e;
        model_reset();

        // Outputs held low while reset is asserted.
        o_rdy = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_ena", o_ena, 0);
        chk("rst_out_v", o_v, 0);
        chk("rst_a_rdy", a_rdy, 0);
        chk("rst_f_rdy", f_rdy, 0);
        chk("rst_cfg_rdy", m_rdy, 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Round-robin interleave with both sources saturating.
        obs_q.delete(); seq_a = 0; seq_f = 0;
        repeat (9) cyc(1, 1, 1, 0, 2'd0);
        chk("rr_count", obs_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            e = '0;
            e[7:4] = (k % 2 == 1) ? 4'hF : 4'hA;
            e[3:0] = 4'(k / 2);
            chk($sformatf("rr_seq%0d", k), obs_q[k], e);
        end
        repeat (3) cyc(0, 0, 1, 0, 2'd0);

        // Single-source latency and idle zero output.
        obs_q.delete();
        force_a = 128'h1234; force_a_en = 1;
        cyc(1, 0, 1, 0, 2'd0);
        force_a_en = 0;
        chk("lat_cycle_n", obs_q.size(), 0);
        cyc(0, 0, 1, 0, 2'd0);
        chk("lat_cycle_n1", obs_q.size(), 1);
        chk("lat_data", obs_q[0], 128'h1234);
        repeat (3) cyc(0, 0, 1, 0, 2'd0);

        // F-priority with starvation cap.
        cyc(0, 0, 1, 1, 2'd1);
        obs_q.delete();
        repeat (16) cyc(1, 1, 1, 0, 2'd0);
        for (int k = 0; k < 15; k++)
            chk($sformatf("fpri_src%0d", k), obs_q[k][7:4], (k % 5 == 4) ? 4'hA : 4'hF);

        // Stalled sink with both slots full, then drain.
        repeat (10) cyc(1, 1, 0, 0, 2'd0);
        obs_q.delete();
        repeat (3) cyc(0, 0, 1, 0, 2'd0);
        chk("stall_drain_count", obs_q.size(), 2);

        // Mode change coinciding with a mode-1 grant.
        cyc(1, 1, 1, 0, 2'd0);
        obs_q.delete();
        cyc(1, 1, 1, 1, 2'd2);
        cyc(0, 0, 1, 0, 2'd0);
        chk("mode_switch_old", obs_q[0][7:4], 4'hF);
        chk("mode_switch_new", obs_q[1][7:4], 4'hA);
        repeat (3) cyc(0, 0, 1, 0, 2'd0);

        // Random traffic, backpressure and mode changes.
        rnd_hi = 1;
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0,
                $urandom_range(15) == 0, 2'($urandom_range(3)));

        // Reset mid-transfer with both slots full.
        repeat (2) cyc(1, 1, 0, 0, 2'd0);
        o_rdy = 1'b1;
        RST = 1'b1;
        #1;
        chk("mid_rst_out_ena", o_ena, 0);
        chk("mid_rst_out_v", o_v, 0);
        chk("mid_rst_a_rdy", a_rdy, 0);
        chk("mid_rst_f_rdy", f_rdy, 0);
        chk("mid_rst_cfg_rdy", m_rdy, 0);
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
        obs_q.delete();
        cyc(1, 1, 1, 0, 2'd0);
        chk("post_rst_empty", obs_q.size(), 0);
        repeat (2) cyc(0, 0, 1, 0, 2'd0);
        chk("post_rst_count", obs_q.size(), 2);
        chk("post_rst_first_a", obs_q[0][7:4], 4'hA);
        chk("post_rst_second_f", obs_q[1][7:4], 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_pipe_arb.md
MUX_PIPE_ARB -- requirements
Module: mux_pipe_arb

Interface
REQ-001 Parameter WIDTH, default 128, payload width of all enq ports.
REQ-002 Parameter STARVE_LIMIT, default 4, range 1..15; the most consecutive losses a waiting source tolerates in fixed-priority mode.
REQ-003 CLK  in  1  single clock; all state rising-edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 in$enq__ENA  in  1  source A enqueue strobe; asserted only while in$enq__RDY=1.
REQ-006 in$enq$v  in  WIDTH  source A payload.
REQ-007 in$enq__RDY  out  1  source A may enqueue.
REQ-008 forward$enq__ENA / forward$enq$v / forward$enq__RDY  in/in/out  1/WIDTH/1  source F, same rules as source A.
REQ-009 out$enq__ENA  out  1  merged output strobe; asserted only while out$enq__RDY=1.
REQ-010 out$enq$v  out  WIDTH  merged payload; 0 when out$enq__ENA=0.
REQ-011 out$enq__RDY  in  1  sink can accept.
REQ-012 cfg$setMode__ENA  in  1  load arbitration mode.
REQ-013 cfg$setMode$v  in  2  mode: 0 round-robin, 1 F-priority, 2 A-priority, 3 reserved (treated as 0).
REQ-014 cfg$setMode__RDY  out  1  constant 1 outside reset.

Function
REQ-015 Each source SHALL own a one-entry slot (valid bit + WIDTH data); enq writes the slot, setting valid.
REQ-016 Slot RDY SHALL be !valid | (slot granted this cycle), so back-to-back enq at one word per cycle is sustained when granted every cycle.
REQ-017 Minimum latency SHALL be one cycle: payload enqueued in cycle N may appear on out$enq$v in cycle N+1; no combinational enq-to-out path.
REQ-018 out$enq__ENA SHALL equal out$enq__RDY & (validA | validF); exactly one slot granted and dequeued per asserted cycle.
REQ-019 Only one slot valid: that slot SHALL be granted, regardless of mode.
REQ-020 Both valid, mode 0: grant the source not granted most recently (1-bit last-grant register, updated on every grant).
REQ-021 Both valid, mode 1/2: grant the priority source unless the starvation counter equals STARVE_LIMIT, in which case grant the other source.
REQ-022 Starvation counter (4 bits) SHALL increment when the non-priority slot is valid and loses a grant, clear when that slot is granted or not valid, and saturate at STARVE_LIMIT.
REQ-023 out$enq__RDY=0: no grant, no dequeue, slots hold data, counter and last-grant hold.
REQ-024 cfg$setMode__ENA SHALL take effect from the next cycle and clear the starvation counter; last-grant is retained; a concurrent grant uses the old mode.
REQ-025 Same-cycle dequeue and enqueue of one slot SHALL leave valid=1 with the new payload.
REQ-026 Data ordering within a source SHALL be preserved; no payload dropped or duplicated.

Reset
REQ-027 While RST=1: both slots invalid, slot data 0, last-grant = F (A wins first round-robin tie), mode 0, counter 0.
REQ-028 While RST=1: out$enq__ENA=0, out$enq$v=0, in$enq__RDY=0, forward$enq__RDY=0, cfg$setMode__RDY=0.
REQ-029 Reset asserted mid-transfer SHALL discard buffered payloads immediately; release yields the REQ-027 state on the next CLK edge.

Structure
REQ-030 Shared package mux_pipe_arb_pkg SHALL hold the mode enumeration, default WIDTH, and default STARVE_LIMIT.
REQ-031 Sub-module mux_pipe_arb_slot (one-entry buffer with enq/deq/valid) SHALL be instantiated twice; arbitration, counter and mode live in the top.

Verification
REQ-032 Mode 0, out$enq__RDY=1, both sources enqueue every cycle (A: 0xA0,0xA1..., F: 0xF0,0xF1...) -> output 0xA0,0xF0,0xA1,0xF1,... one per cycle, no gaps.
REQ-033 Mode 1, STARVE_LIMIT=4, both saturated -> F,F,F,F,A repeating; A waits at most 4 grants.
REQ-034 Both slots full, out$enq__RDY low 10 cycles -> ENA stays 0, both enq RDY 0, contents unchanged; RDY high -> both words drain in order.
REQ-035 Only A active, payload 0x1234 in cycle N, sink ready -> out$enq__ENA=1, out$enq$v=0x1234 in cycle N+1; out$enq$v=0 in all idle cycles.
REQ-036 RST pulsed with both slots full -> outputs 0 immediately; after release the first tie grants A; buffered data never appears.
REQ-037 setMode(2) issued the same cycle as a mode-1 grant -> that grant follows mode 1, next tie grants A, counter restarts at 0.
